// File: rtl/serial_pkg.sv
// Shared types and constants for the serial line receive path.
package serial_pkg;

  localparam int unsigned SERIAL_DATA_W = 8;

  // Logical level of an idle line after polarity correction.
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  function automatic logic even_parity(input logic [SERIAL_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; both stages reset to 1.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_protocol_rx.sv
// Serial line receiver: synchronizes one pad, de-frames start/data/[parity]/stop bits.
// Optional even-parity bit enabled with SERIAL_RX_PARITY_EN.
module serial_protocol_rx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_i,
  input  logic                     polarity_i,
  output logic [SERIAL_DATA_W-1:0] data_o,
  output logic                     valid_o,
  output logic                     frame_err_o,
  output logic                     busy_o
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic                     parity_err_o
`endif
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

  logic sync_rx;
  logic line;

  rx_state_e                state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [SERIAL_DATA_W-1:0] shift_q, shift_d;
  logic [SERIAL_DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                     par_bad_q, par_bad_d;
  logic                     perr_q, perr_d;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (sync_rx)
  );

  // Idle-low lines are inverted so the FSM always sees idle = 1, start = 0.
  assign line = sync_rx ^ ~polarity_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (line != IDLE_LEVEL) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = 3'd0;
          state_d = (line == IDLE_LEVEL) ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = line;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StParity: begin
`ifdef SERIAL_RX_PARITY_EN
        if (cnt_q == FullLast) begin
          cnt_d     = '0;
          par_bad_d = line ^ even_parity(shift_q);
          state_d   = StStop;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d = '0;
          if (line == IDLE_LEVEL) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (line == IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_serial_protocol_rx.sv
// Bench for serial_protocol_rx: table of frames plus corner-case sequences, scoreboarded.
module tb_serial_protocol_rx;

  localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int Lat = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int Lat = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       polarity;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef SERIAL_RX_PARITY_EN
  logic       parity_err;
`endif

  serial_protocol_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .polarity_i   (polarity),
    .data_o       (data),
    .valid_o      (valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
`ifdef SERIAL_RX_PARITY_EN
    ,
    .parity_err_o (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
    logic       perr;
  } exp_t;

  typedef struct {
    logic       pol;
    logic [7:0] b;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         last_e0 = 0;
  int         busy_rise = -1;
  logic [7:0] last_good = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid || frame_err) begin
        chk("strobe_exclusive", {31'd0, valid & frame_err}, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%02h, required none",
                   valid, frame_err, data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
          chk("data", {24'd0, data}, {24'd0, mon_e.data});
          chk("strobe_cycle", cyc, mon_e.cyc);
          if (valid) chk("busy_fall", {31'd0, busy}, 0);
`ifdef SERIAL_RX_PARITY_EN
          chk("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
`endif
        end
      end
      if (prev_valid) chk("valid_width", {31'd0, valid}, 0);
      if (busy && !prev_busy) busy_rise = cyc;
      prev_valid = valid;
      prev_busy  = busy;
    end else begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx = polarity ? b : ~b;
    repeat (CPB) @(negedge clk);
  endtask

  // Must be entered at a falling edge so back-to-back frames stay exactly spaced.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    exp_t e;
    last_e0  = cyc + 1;
    e.is_err = ~stop_bit;
    e.data   = stop_bit ? b : last_good;
    e.cyc    = last_e0 + Lat;
    e.perr   = par_flip & stop_bit;
    if (stop_bit) last_good = b;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic idle_cycles(input int n);
    rx = polarity;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    chk("data_hold", {24'd0, data}, {24'd0, last_good});
    idle_cycles(CPB);
  endtask

  task automatic set_pol(input logic p);
    polarity = p;
    idle_cycles(40);
  endtask

  vec_t vecs[8];
  int   busy_cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'hA5};
    vecs[1] = '{1'b0, 8'hA5};
    vecs[2] = '{1'b1, 8'h00};
    vecs[3] = '{1'b1, 8'hFF};
    vecs[4] = '{1'b0, 8'h3C};
    vecs[5] = '{1'b1, 8'h81};
    vecs[6] = '{1'b0, 8'h7E};
    vecs[7] = '{1'b1, 8'h01};

    polarity = 1'b1;
    rx       = 1'b1;
    rst      = 1'b0;
    #1 rst   = 1'b1;
    #1;
    chk("rst_data", {24'd0, data}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(10);

    // Bad stop bit, line held low, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("break_busy", {31'd0, busy}, 1);
    idle_cycles(2 * CPB);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_drain("ferr_drain");
    chk("busy_rise", busy_rise, last_e0 + 2);

    // Short low glitch on the idle line.
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) rx = 1'b0;
      if (i == 6) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_range", {31'd0, (busy_cnt > 0) && (busy_cnt <= 8)}, 1);
    chk("glitch_busy_end", {31'd0, busy}, 0);
    wait_drain("glitch_drain");

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].pol != polarity) set_pol(vecs[v].pol);
      send_frame(vecs[v].b, 1'b1, 1'b0);
      idle_cycles(2 * CPB);
      wait_drain("table_drain");
    end
    if (polarity != 1'b1) set_pol(1'b1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle_cycles(CPB);
    wait_drain("b2b_drain");

    // Reset in the middle of data bit 4 of 0x96.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'h96 >> i) & 8'h01));
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data", {24'd0, data}, 0);
    chk("midrst_valid", {31'd0, valid}, 0);
    chk("midrst_frame_err", {31'd0, frame_err}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(40);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_drain("midrst_drain");

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("parity_bad_drain");
    send_frame(8'h07, 1'b1, 1'b0);
    wait_drain("parity_good_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
